// File: rtl/cprv_wb_stage_if.sv
// Handshake and bus bundle for the cprv64 write-back stage: mem-stage
// instruction input, data-memory read response and register-file write port.
interface cprv_wb_stage_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid_wb_i;
  logic                  ready_wb_o;
  logic [4:0]            rd_addr_wb_i;
  logic                  rd_en_wb_i;
  logic [6:0]            opcode_wb_i;
  logic [2:0]            funct3_wb_i;
  logic [DATA_WIDTH-1:0] alu_out_wb_i;
  logic                  valid_wb_dmem_i;
  logic                  ready_wb_dmem_o;
  logic [DATA_WIDTH-1:0] rdata_dmem_i;
  logic                  rd_we_o;
  logic [4:0]            rd_waddr_o;
  logic [DATA_WIDTH-1:0] rd_wdata_o;

  modport master (
    output valid_wb_i, rd_addr_wb_i, rd_en_wb_i, opcode_wb_i, funct3_wb_i,
           alu_out_wb_i, valid_wb_dmem_i, rdata_dmem_i,
    input  ready_wb_o, ready_wb_dmem_o, rd_we_o, rd_waddr_o, rd_wdata_o
  );

  modport slave (
    input  valid_wb_i, rd_addr_wb_i, rd_en_wb_i, opcode_wb_i, funct3_wb_i,
           alu_out_wb_i, valid_wb_dmem_i, rdata_dmem_i,
    output ready_wb_o, ready_wb_dmem_o, rd_we_o, rd_waddr_o, rd_wdata_o
  );
endinterface

// File: rtl/cprv_wb_stage.sv
// cprv64 write-back stage: retires instructions, formats load data, drives the
// register-file write port. Define CPRV_WB_INSTRET_EN to add the instret_o counter.
module cprv_wb_stage #(
  parameter int       DATA_WIDTH = 64,
  parameter bit [6:0] OPC_LOAD   = 7'b0000011,
  parameter bit [6:0] OPC_STORE  = 7'b0100011,
  parameter bit [6:0] OPC_BRANCH = 7'b1100011
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CPRV_WB_INSTRET_EN
  output logic [63:0]      instret_o,
`endif
  cprv_wb_stage_if.slave   wb
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOAD_WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  rd_we_q, rd_we_d;
  logic [4:0]            rd_waddr_q, rd_waddr_d;
  logic [DATA_WIDTH-1:0] rd_wdata_q, rd_wdata_d;
  logic [4:0]            cap_rd_q, cap_rd_d;
  logic                  cap_en_q, cap_en_d;
  logic [2:0]            cap_funct3_q, cap_funct3_d;
  logic [2:0]            cap_addr_q, cap_addr_d;
  logic                  is_load_s;
  logic                  writes_rd_s;
  logic                  done_s;
  logic                  ready_s;
  logic                  dmem_ready_s;

  // Lane select by address offset, then sign/zero extend by funct3.
  function automatic logic [DATA_WIDTH-1:0] load_fmt(
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [2:0]            f3,
    input logic [2:0]            a
  );
    logic [DATA_WIDTH-1:0] sb, sh, sw;
    sb = rdata >> {a, 3'b000};
    sh = rdata >> {a[2:1], 4'b0000};
    sw = rdata >> {a[2], 5'b00000};
    case (f3)
      3'b000:  load_fmt = {{(DATA_WIDTH-8){sb[7]}}, sb[7:0]};
      3'b001:  load_fmt = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b010:  load_fmt = {{(DATA_WIDTH-32){sw[31]}}, sw[31:0]};
      3'b011:  load_fmt = rdata;
      3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, sb[7:0]};
      3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      3'b110:  load_fmt = {{(DATA_WIDTH-32){1'b0}}, sw[31:0]};
      default: load_fmt = {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  assign is_load_s   = (wb.opcode_wb_i == OPC_LOAD);
  assign writes_rd_s = wb.rd_en_wb_i && (wb.rd_addr_wb_i != 5'd0) &&
                       (wb.opcode_wb_i != OPC_STORE) && (wb.opcode_wb_i != OPC_BRANCH);

  // Next-state, handshake and write-port logic.
  always_comb begin
    state_d      = state_q;
    rd_we_d      = 1'b0;
    rd_waddr_d   = rd_waddr_q;
    rd_wdata_d   = rd_wdata_q;
    cap_rd_d     = cap_rd_q;
    cap_en_d     = cap_en_q;
    cap_funct3_d = cap_funct3_q;
    cap_addr_d   = cap_addr_q;
    done_s       = 1'b0;
    ready_s      = 1'b0;
    dmem_ready_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_s      = 1'b1;
        dmem_ready_s = wb.valid_wb_i && is_load_s;
        if (wb.valid_wb_i && (!is_load_s || wb.valid_wb_dmem_i)) begin
          done_s  = 1'b1;
          rd_we_d = writes_rd_s;
          if (writes_rd_s) begin
            rd_waddr_d = wb.rd_addr_wb_i;
            rd_wdata_d = is_load_s ?
                         load_fmt(wb.rdata_dmem_i, wb.funct3_wb_i, wb.alu_out_wb_i[2:0]) :
                         wb.alu_out_wb_i;
          end else begin
            rd_waddr_d = rd_waddr_q;
            rd_wdata_d = rd_wdata_q;
          end
        end else if (wb.valid_wb_i) begin
          // Load whose data is not back yet: remember what formatting needs.
          cap_rd_d     = wb.rd_addr_wb_i;
          cap_en_d     = wb.rd_en_wb_i;
          cap_funct3_d = wb.funct3_wb_i;
          cap_addr_d   = wb.alu_out_wb_i[2:0];
          state_d      = S_LOAD_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_WAIT: begin
        dmem_ready_s = 1'b1;
        if (wb.valid_wb_dmem_i) begin
          done_s  = 1'b1;
          state_d = S_IDLE;
          rd_we_d = cap_en_q && (cap_rd_q != 5'd0);
          if (cap_en_q && (cap_rd_q != 5'd0)) begin
            rd_waddr_d = cap_rd_q;
            rd_wdata_d = load_fmt(wb.rdata_dmem_i, cap_funct3_q, cap_addr_q);
          end else begin
            rd_waddr_d = rd_waddr_q;
            rd_wdata_d = rd_wdata_q;
          end
        end else begin
          state_d = S_LOAD_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_we_q      <= 1'b0;
      rd_waddr_q   <= 5'd0;
      rd_wdata_q   <= {DATA_WIDTH{1'b0}};
      cap_rd_q     <= 5'd0;
      cap_en_q     <= 1'b0;
      cap_funct3_q <= 3'd0;
      cap_addr_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      rd_we_q      <= rd_we_d;
      rd_waddr_q   <= rd_waddr_d;
      rd_wdata_q   <= rd_wdata_d;
      cap_rd_q     <= cap_rd_d;
      cap_en_q     <= cap_en_d;
      cap_funct3_q <= cap_funct3_d;
      cap_addr_q   <= cap_addr_d;
    end
  end

  assign wb.ready_wb_o      = ready_s;
  assign wb.ready_wb_dmem_o = dmem_ready_s;
  assign wb.rd_we_o         = rd_we_q;
  assign wb.rd_waddr_o      = rd_waddr_q;
  assign wb.rd_wdata_o      = rd_wdata_q;

`ifdef CPRV_WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Retired-instruction count, wrapping naturally at 2^64.
  always_comb begin
    if (done_s) begin
      instret_d = instret_q + 64'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;
`endif

endmodule
